// File: rtl/timestamp_capture_arbiter.sv
// timestamp_capture_arbiter: prescaled Gray-counter enable, per-port timestamp
// capture slots, round-robin drain onto one valid/ready record channel.
// Ports: clk, rst_n (async low); cnt_enable/cnt_value to/from the counter;
// cap_req/cap_drop per port; m_tvalid/m_tready/m_tdata/m_tid record channel;
// m_tepoch only when TS_ARB_EPOCH_EN is defined.
module timestamp_capture_arbiter #(
  parameter int N_PORTS = 4,
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] WRAP_VALUE = '0,
  parameter int PRESCALE = 8,
  parameter int EPOCH_W = 16,
  localparam int TW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               cnt_enable,
  input  logic [WIDTH-1:0]   cnt_value,
  input  logic [N_PORTS-1:0] cap_req,
  output logic [N_PORTS-1:0] cap_drop,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic [WIDTH-1:0]   m_tdata,
  output logic [TW-1:0]      m_tid
`ifdef TS_ARB_EPOCH_EN
  ,
  output logic [EPOCH_W-1:0] m_tepoch
`endif
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {EMPTY, VALID} state_t;

  state_t             state;
  logic [CW-1:0]      pcnt;
  logic [CW-1:0]      pcnt_nx;
  logic [N_PORTS-1:0] full;
  logic [WIDTH-1:0]   sdata [N_PORTS];
  logic [TW-1:0]      rr_ptr;
  logic [TW-1:0]      gnt_idx;
  logic [TW-1:0]      cand;
  logic               gnt_any;
  logic               take;
  logic [N_PORTS-1:0] gnt_vec;
  int                 sum;

`ifdef TS_ARB_EPOCH_EN
  logic [EPOCH_W-1:0] epoch;
  logic [EPOCH_W-1:0] sepoch [N_PORTS];
`endif

  // Enable is registered so it is low during and right after reset.
  always_comb begin
    pcnt_nx = (pcnt == CW'(PRESCALE-1)) ? '0 : pcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      cnt_enable <= 1'b0;
    end else begin
      pcnt <= pcnt_nx;
      cnt_enable <= (pcnt_nx == CW'(PRESCALE-1));
    end
  end

  // Round-robin search from rr_ptr over full slots.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand = '0;
    sum = 0;
    for (int k = 0; k < N_PORTS; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= N_PORTS) sum = sum - N_PORTS;
      cand = TW'(sum);
      if (!gnt_any && full[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    take = gnt_any && ((state == EMPTY) || m_tready);
    gnt_vec = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      gnt_vec[i] = take && (gnt_idx == TW'(i));
    end
  end

  // A slot being drained this cycle can accept a new capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
      cap_drop <= '0;
      for (int i = 0; i < N_PORTS; i++) begin
        sdata[i] <= '0;
`ifdef TS_ARB_EPOCH_EN
        sepoch[i] <= '0;
`endif
      end
    end else begin
      cap_drop <= cap_req & full & ~gnt_vec;
      for (int i = 0; i < N_PORTS; i++) begin
        if (cap_req[i] && (!full[i] || gnt_vec[i])) begin
          full[i] <= 1'b1;
          sdata[i] <= cnt_value;
`ifdef TS_ARB_EPOCH_EN
          sepoch[i] <= epoch;
`endif
        end else if (gnt_vec[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

`ifdef TS_ARB_EPOCH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epoch <= '0;
    end else if (cnt_enable && (cnt_value == WRAP_VALUE)) begin
      epoch <= epoch + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      m_tvalid <= 1'b0;
      m_tdata <= '0;
      m_tid <= '0;
      rr_ptr <= '0;
`ifdef TS_ARB_EPOCH_EN
      m_tepoch <= '0;
`endif
    end else begin
      unique case (state)
        EMPTY: begin
          if (gnt_any) begin
            state <= VALID;
            m_tvalid <= 1'b1;
          end
        end
        VALID: begin
          if (m_tready && !gnt_any) begin
            state <= EMPTY;
            m_tvalid <= 1'b0;
          end
        end
        default: begin
          state <= EMPTY;
          m_tvalid <= 1'b0;
        end
      endcase
      if (take) begin
        m_tdata <= sdata[gnt_idx];
        m_tid <= gnt_idx;
`ifdef TS_ARB_EPOCH_EN
        m_tepoch <= sepoch[gnt_idx];
`endif
        rr_ptr <= (gnt_idx == TW'(N_PORTS-1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_timestamp_capture_arbiter.sv
// tb_timestamp_capture_arbiter: directed stimulus, queue-free slot model
// compared every cycle, plus literal checks of the headline scenarios.
module tb_timestamp_capture_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int P = 8;
  localparam int EW = 16;
  localparam logic [W-1:0] WRAP = '0;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cnt_enable;
  logic [W-1:0]  cnt_value;
  logic [N-1:0]  cap_req;
  logic [N-1:0]  cap_drop;
  logic          m_tvalid;
  logic          m_tready;
  logic [W-1:0]  m_tdata;
  logic [TW-1:0] m_tid;
`ifdef TS_ARB_EPOCH_EN
  logic [EW-1:0] m_tepoch;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  timestamp_capture_arbiter #(
    .N_PORTS(N), .WIDTH(W), .WRAP_VALUE(WRAP),
    .PRESCALE(P), .EPOCH_W(EW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cnt_enable(cnt_enable), .cnt_value(cnt_value),
    .cap_req(cap_req), .cap_drop(cap_drop),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tid(m_tid)
`ifdef TS_ARB_EPOCH_EN
    , .m_tepoch(m_tepoch)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: pending events per port, one output record, RR start port.
  bit            p_full [N];
  logic [W-1:0]  p_data [N];
  logic [EW-1:0] p_ep [N];
  bit            x_valid;
  logic [W-1:0]  x_data;
  int            x_id;
  logic [EW-1:0] x_ep;
  logic [N-1:0]  x_drop;
  int            rr;
  int            cyc;
  int            gi;
  logic [EW-1:0] ep;

  function automatic bit model_en(input int c);
    if (P == 1) return c >= 1;
    return (c % P) == (P - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        p_full[i] = 0;
        p_data[i] = '0;
        p_ep[i] = '0;
      end
      x_valid = 0; x_data = '0; x_id = 0; x_ep = '0;
      x_drop = '0; rr = 0; cyc = 0; ep = '0;
    end else begin
      if (!x_valid || m_tready) begin
        gi = -1;
        for (int k = 0; k < N; k++)
          if (gi < 0 && p_full[(rr + k) % N]) gi = (rr + k) % N;
        if (gi >= 0) begin
          x_valid = 1;
          x_data = p_data[gi];
          x_id = gi;
          x_ep = p_ep[gi];
          p_full[gi] = 0;
          rr = (gi + 1) % N;
        end else begin
          x_valid = 0;
        end
      end
      x_drop = '0;
      for (int i = 0; i < N; i++) begin
        if (cap_req[i]) begin
          if (p_full[i]) x_drop[i] = 1'b1;
          else begin
            p_full[i] = 1;
            p_data[i] = cnt_value;
            p_ep[i] = ep;
          end
        end
      end
      if (model_en(cyc) && cnt_value == WRAP) ep = ep + 1'b1;
      cyc++;
    end
  end

  always @(negedge clk) begin
    chk("cnt_enable", cnt_enable, model_en(cyc));
    chk("m_tvalid", m_tvalid, x_valid);
    chk("cap_drop", cap_drop, x_drop);
    if (x_valid) begin
      chk("m_tdata", m_tdata, x_data);
      chk("m_tid", m_tid, x_id[TW-1:0]);
`ifdef TS_ARB_EPOCH_EN
      chk("m_tepoch", m_tepoch, x_ep);
`endif
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next();
    rst_n = 1'b0;
    cap_req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [N-1:0] tbl_req [16];
  bit           tbl_rdy [16];

  initial begin
    rst_n = 1'b1;
    cap_req = '0;
    m_tready = 1'b0;
    cnt_value = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state and prescaler pulses
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tid", m_tid, 0);
        chk("rst_drop", cap_drop, 0);
      end
      chk("prescale", cnt_enable, (c == 7 || c == 15 || c == 23));
      next();
    end

    // single capture, latency 2
    m_tready = 1'b1;
    cnt_value = 32'h5;
    cap_req = 4'b0100;
    next();
    cap_req = '0;
    next();
    @(negedge clk);
    chk("t2_valid", m_tvalid, 1);
    chk("t2_data", m_tdata, 32'h5);
    chk("t2_tid", m_tid, 2);
    next();
    @(negedge clk);
    chk("t2_gone", m_tvalid, 0);

    // fairness, two bursts from a fresh pointer
    do_reset();
    for (int b = 0; b < 2; b++) begin
      cnt_value = 32'hA + b;
      cap_req = 4'b1111;
      next();
      cap_req = '0;
      next();
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("t3_valid", m_tvalid, 1);
        chk("t3_tid", m_tid, k);
        chk("t3_data", m_tdata, 32'hA + b);
        next();
      end
      @(negedge clk);
      chk("t3_idle", m_tvalid, 0);
      next();
    end

    // backpressure on port 1
    m_tready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      cnt_value = 32'(p + 1);
      cap_req = 4'b0010;
      next();
      cap_req = '0;
      if (p < 2) next();
    end
    @(negedge clk);
    chk("t4_drop", cap_drop, 4'b0010);
    chk("t4_hold", m_tdata, 32'h1);
    next();
    m_tready = 1'b1;
    @(negedge clk);
    chk("t4_rec1", m_tdata, 32'h1);
    chk("t4_nodrop", cap_drop, 0);
    next();
    @(negedge clk);
    chk("t4_rec2", m_tdata, 32'h2);
    chk("t4_tid2", m_tid, 1);
    next();
    @(negedge clk);
    chk("t4_idle", m_tvalid, 0);
    next();

    // refill on grant
    cnt_value = 32'h7;
    cap_req = 4'b0001;
    next();
    cnt_value = 32'h8;
    next();
    cap_req = '0;
    @(negedge clk);
    chk("t5_nodrop", cap_drop, 0);
    chk("t5_rec1", m_tdata, 32'h7);
    next();
    @(negedge clk);
    chk("t5_rec2", m_tdata, 32'h8);
    chk("t5_valid2", m_tvalid, 1);
    next();
    @(negedge clk);
    chk("t5_idle", m_tvalid, 0);
    next();

    // reset with pending work discards it silently
    m_tready = 1'b0;
    cnt_value = 32'h33;
    cap_req = 4'b1001;
    repeat (3) next();
    do_reset();
    @(negedge clk);
    chk("rst_mid_valid", m_tvalid, 0);
    chk("rst_mid_drop", cap_drop, 0);
    next();

    // mixed directed table, model-checked each cycle
    tbl_req = '{4'b0001, 4'b0110, 4'b1111, 4'b0000,
                4'b1010, 4'b1010, 4'b0101, 4'b0000,
                4'b1111, 4'b1111, 4'b0000, 4'b1000,
                4'b0011, 4'b0000, 4'b1100, 4'b0000};
    tbl_rdy = '{1, 1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1, 1, 1, 1};
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) begin
        cnt_value = 32'(16'h100 + r * 16 + i);
        cap_req = tbl_req[i];
        m_tready = (r == 1) ? 1'b1 : tbl_rdy[i];
        next();
      end
    end
    cap_req = '0;
    m_tready = 1'b1;
    repeat (8) next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
